ps2_host_ctl: RTL

Host-side PS/2 bus controller that owns the two open-drain lines (`clk`/`dat` on the wire, 10–16.7 kHz device clock) and schedules them between device-to-host frame reception and host-to-device command transmission. It sits between the board pins and the keyboard/command logic. It presents byte-wide receive and transmit interfaces, and performs all bus inhibit, request-to-send, framing, parity and acknowledge sequencing.

---
 rtl/ps2_host_ctl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_host_ctl.sv
// PS/2 host controller: conditions the open-drain clock/data lines and sequences
// device-to-host frame reception and host-to-device command transmission.
module ps2_host_ctl #(
  parameter int unsigned INHIBIT_CYCLES = 100,
  parameter int unsigned TIMEOUT_CYCLES = 2000,
  parameter int unsigned FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_err,
  output logic       busy
);
  localparam int unsigned CntMax =
      (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CW = $clog2(CntMax + 1);
  localparam int unsigned FW = $clog2(FILTER_LEN + 1);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRx     = 3'd1;
  localparam logic [2:0] StTxInh  = 3'd2;
  localparam logic [2:0] StTxRts  = 3'd3;
  localparam logic [2:0] StTxBits = 3'd4;
  localparam logic [2:0] StTxAck  = 3'd5;
  localparam logic [2:0] StTxRel  = 3'd6;

  logic          clk_s1, clk_s2, dat_s1, dat_s2, clk_f, fe;
  logic [FW-1:0] flt_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      dat_s1  <= 1'b1;
      dat_s2  <= 1'b1;
      clk_f   <= 1'b1;
      flt_cnt <= '0;
      fe      <= 1'b0;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_dat_in;
      dat_s2 <= dat_s1;
      fe     <= 1'b0;
      if (clk_s2 == clk_f) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_f   <= clk_s2;
        flt_cnt <= '0;
        fe      <= ~clk_s2;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  logic [2:0]    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [10:0]   rx_sh_q, rx_sh_d, rx_next;
  logic [9:0]    tx_sh_q, tx_sh_d;
  logic          ack_q, ack_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          clk_oe_q, clk_oe_d, dat_oe_q, dat_oe_d;
  logic          tx_done_d, tx_err_d, rx_valid_d, rx_err_d;
  logic [7:0]    rx_data_d;
  logic          timeout;

  assign rx_next = {dat_s2, rx_sh_q[10:1]};
  // Counter starts at 1 on every fe so a timeout lands exactly TIMEOUT_CYCLES after it.
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_sh_d    = rx_sh_q;
    tx_sh_d    = tx_sh_q;
    ack_d      = ack_q;
    cnt_d      = cnt_q;
    clk_oe_d   = clk_oe_q;
    dat_oe_d   = dat_oe_q;
    rx_data_d  = rx_data;
    tx_done_d  = 1'b0;
    tx_err_d   = 1'b0;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = CW'(1);
        if (fe) begin
          rx_sh_d   = rx_next;
          bit_cnt_d = 4'd1;
          state_d   = StRx;
        end else if (tx_valid) begin
          tx_sh_d  = {1'b1, ~^tx_data, tx_data};
          cnt_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = StTxInh;
        end
      end
      StRx: begin
        if (fe) begin
          rx_sh_d   = rx_next;
          bit_cnt_d = bit_cnt_q + 4'd1;
          cnt_d     = CW'(1);
          if (bit_cnt_q == 4'd10) begin
            state_d = StIdle;
            if (!rx_next[0] && (^rx_next[9:1]) && rx_next[10]) begin
              rx_valid_d = 1'b1;
              rx_data_d  = rx_next[8:1];
            end else begin
              rx_err_d = 1'b1;
            end
          end
        end else if (timeout) begin
          rx_err_d = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StTxInh: begin
        // RTS cycle is the last of the INHIBIT_CYCLES clock-low cycles.
        if (cnt_q == CW'(INHIBIT_CYCLES - 2)) begin
          dat_oe_d = 1'b1;
          state_d  = StTxRts;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StTxRts: begin
        clk_oe_d  = 1'b0;
        bit_cnt_d = 4'd0;
        cnt_d     = CW'(1);
        state_d   = StTxBits;
      end
      StTxBits, StTxAck, StTxRel: begin
        if (state_q == StTxRel && clk_f && dat_s2) begin
          tx_done_d = ack_q;
          tx_err_d  = ~ack_q;
          state_d   = StIdle;
        end else if (fe && state_q == StTxBits) begin
          dat_oe_d  = ~tx_sh_q[0];
          tx_sh_d   = {1'b1, tx_sh_q[9:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          cnt_d     = CW'(1);
          if (bit_cnt_q == 4'd9) state_d = StTxAck;
        end else if (fe && state_q == StTxAck) begin
          ack_d   = ~dat_s2;
          cnt_d   = CW'(1);
          state_d = StTxRel;
        end else if (timeout) begin
          clk_oe_d = 1'b0;
          dat_oe_d = 1'b0;
          tx_err_d = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      rx_sh_q   <= '0;
      tx_sh_q   <= '0;
      ack_q     <= 1'b0;
      cnt_q     <= '0;
      clk_oe_q  <= 1'b0;
      dat_oe_q  <= 1'b0;
      rx_data   <= 8'h00;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
      rx_valid  <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_sh_q   <= rx_sh_d;
      tx_sh_q   <= tx_sh_d;
      ack_q     <= ack_d;
      cnt_q     <= cnt_d;
      clk_oe_q  <= clk_oe_d;
      dat_oe_q  <= dat_oe_d;
      rx_data   <= rx_data_d;
      tx_done   <= tx_done_d;
      tx_err    <= tx_err_d;
      rx_valid  <= rx_valid_d;
      rx_err    <= rx_err_d;
    end
  end

  assign ps2_clk_oe = clk_oe_q;
  assign ps2_dat_oe = dat_oe_q;
  assign tx_ready   = (state_q == StIdle) && !fe;
  assign busy       = (state_q != StIdle);

endmodule
